// File: rtl/spi_0_arbiter.sv
// Two requesters share one mode-0 SPI master. GNTn pulses in LOAD and DONEn pulses 16*CLK_DIV+1 cycles later.
// Requests wait while BUSY. SPI_0_ARB_ROUND_ROBIN_EN selects round robin on ties; otherwise REQ0 has fixed priority.
`timescale 1ns/1ps
module spi_0_arbiter #(
  parameter int CLK_DIV = 4
) (
  input  logic       FAB_CCC_GL0,
  input  logic       FAB_RESET,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [7:0] TX_DATA0,
  input  logic [7:0] TX_DATA1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       DONE0,
  output logic       DONE1,
  output logic [7:0] RX_DATA,
  output logic       BUSY,
  output logic       SPI_0_CLK,
  output logic       SPI_0_SS0,
  output logic       SPI_0_DO,
  input  logic       SPI_0_DI
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state;
  logic       owner;
  logic [6:0] tx_sr;
  logic [7:0] rx_sr;
  logic [7:0] div_cnt;
  logic [3:0] edge_cnt;
  logic       pick1;
  logic [7:0] win_data;

`ifdef SPI_0_ARB_ROUND_ROBIN_EN
  logic rr_prio;  // requester favoured on a tie: 0 or 1

  assign pick1 = REQ1 & (~REQ0 | rr_prio);

  always_ff @(posedge FAB_CCC_GL0) begin
    if (FAB_RESET) begin
      rr_prio <= 1'b0;
    end else if (state == IDLE && (REQ0 || REQ1)) begin
      rr_prio <= ~pick1;
    end
  end
`else
  assign pick1 = REQ1 & ~REQ0;
`endif

  assign win_data = pick1 ? TX_DATA1 : TX_DATA0;

  always_ff @(posedge FAB_CCC_GL0) begin
    if (FAB_RESET) begin
      state     <= IDLE;
      owner     <= 1'b0;
      tx_sr     <= 7'd0;
      rx_sr     <= 8'd0;
      div_cnt   <= 8'd0;
      edge_cnt  <= 4'd0;
      GNT0      <= 1'b0;
      GNT1      <= 1'b0;
      DONE0     <= 1'b0;
      DONE1     <= 1'b0;
      RX_DATA   <= 8'h00;
      BUSY      <= 1'b0;
      SPI_0_CLK <= 1'b0;
      SPI_0_SS0 <= 1'b1;
      SPI_0_DO  <= 1'b0;
    end else begin
      GNT0  <= 1'b0;
      GNT1  <= 1'b0;
      DONE0 <= 1'b0;
      DONE1 <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ0 || REQ1) begin
            state     <= LOAD;
            owner     <= pick1;
            tx_sr     <= win_data[6:0];
            SPI_0_DO  <= win_data[7];
            SPI_0_SS0 <= 1'b0;
            SPI_0_CLK <= 1'b0;
            BUSY      <= 1'b1;
            GNT0      <= ~pick1;
            GNT1      <= pick1;
            div_cnt   <= 8'd0;
            edge_cnt  <= 4'd0;
          end
        end
        LOAD: begin
          state <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt   <= 8'd0;
            SPI_0_CLK <= ~SPI_0_CLK;
            edge_cnt  <= edge_cnt + 4'd1;
            if (!SPI_0_CLK) begin
              rx_sr <= {rx_sr[6:0], SPI_0_DI};
            end else if (edge_cnt == 4'd15) begin
              // eighth falling edge closes the byte
              state     <= DONE;
              SPI_0_SS0 <= 1'b1;
              SPI_0_DO  <= 1'b0;
              RX_DATA   <= rx_sr;
              DONE0     <= ~owner;
              DONE1     <= owner;
            end else begin
              SPI_0_DO <= tx_sr[6];
              tx_sr    <= {tx_sr[5:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
